// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM state encoding and mode codes.
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage : count_seq_pkg

// File: rtl/count_prescaler.sv
// Clock-enable prescaler: a small free counter that pulses tick once every
// 2^sel cycles while it is allowed to advance. clear wins over hold.
module count_prescaler #(
  parameter int PRESC_W = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       hold,
  input  logic [1:0] sel,
  output logic       tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;
  logic [PRESC_W-1:0] last_val;

  // Last phase of the current period; sel=0 makes every cycle a tick.
  assign last_val = PRESC_W'((1 << sel) - 1);
  assign tick     = (cnt_q == last_val);

  // Next phase: clear, hold, or advance and fold back to 0 after the tick.
  always_comb begin
    // NOTE: the default assignment on entry keeps every path assigned, so no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (!hold) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      cnt_q <= cnt_d;
    end
  end

endmodule : count_prescaler

// File: rtl/count_sequencer.sv
// Sequencer for a WIDTH-bit up-counter: start/pause/stop/load commands,
// programmable terminal count, one-shot or auto-reload, and a 1/2/4/8 prescaler.
module count_sequencer
  import count_seq_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int PRESC_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] term_val,
  input  logic             mode,
  input  logic [1:0]       presc_sel,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap,
  output logic [1:0]       state
);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_inc_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] term_q;
  logic             mode_q;
  logic [1:0]       presc_q;
  logic             done_q;
  logic             wrap_q;

  logic             idle_like;
  logic             start_accept;
  logic             presc_clear;
  logic             presc_hold;
  logic             tick;

  // A new run may only be launched from IDLE or DONE; PAUSED uses start to resume.
  assign idle_like    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign start_accept = start && idle_like;

  // The prescaler restarts its phase on a fresh run or an abort, and only
  // advances in RUN cycles that are not being paused.
  assign presc_clear = stop || start_accept;
  assign presc_hold  = (state_q != ST_RUN) || pause;

  // Plain increment; the WIDTH-bit result wraps 15 -> 0 for the default width.
  assign count_inc_d = count_q + 1'b1;

  count_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clear (presc_clear),
    .hold  (presc_hold),
    .sel   (presc_q),
    .tick  (tick)
  );

  // Control FSM together with the sampled run settings and the counter datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      term_q   <= '0;
      mode_q   <= MODE_ONESHOT;
      presc_q  <= '0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (stop) begin
        // Abort wins over everything, including a coincident terminal tick.
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE, ST_DONE: begin
            if (load_en) begin
              count_q  <= load_val;
              reload_q <= load_val;
            end
            if (start) begin
              term_q  <= term_val;
              mode_q  <= mode;
              presc_q <= presc_sel;
              state_q <= ST_RUN;
            end
          end
          ST_RUN: begin
            if (pause) begin
              state_q <= ST_PAUSED;
            end else if (tick) begin
              if (count_q == term_q) begin
                if (mode_q == MODE_ONESHOT) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end else begin
                  count_q <= reload_q;
                  wrap_q  <= 1'b1;
                end
              end else begin
                count_q <= count_inc_d;
              end
            end
          end
          ST_PAUSED: begin
            if (start) begin
              state_q <= ST_RUN;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign count = count_q;
  assign busy  = (state_q == ST_RUN) || (state_q == ST_PAUSED);
  assign done  = done_q;
  assign wrap  = wrap_q;
  assign state = state_q;

endmodule : count_sequencer

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios followed by
// randomized command traffic, all compared against a behavioural model.
module tb_count_sequencer;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             pause;
  logic             stop;
  logic             load_en;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] term_val;
  logic             mode;
  logic [1:0]       presc_sel;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             wrap;
  logic [1:0]       state;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: state as plain integers, prescaler as a running
  // cycle counter taken modulo the division ratio.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;
  int m_state, m_count, m_reload, m_term, m_mode, m_presc, m_phase;
  int m_done, m_wrap;

  count_sequencer #(
    .WIDTH   (WIDTH),
    .PRESC_W (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pause     (pause),
    .stop      (stop),
    .load_en   (load_en),
    .load_val  (load_val),
    .term_val  (term_val),
    .mode      (mode),
    .presc_sel (presc_sel),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_count = 0; m_reload = 0; m_term = 0;
    m_mode = 0; m_presc = 0; m_phase = 0; m_done = 0; m_wrap = 0;
  endtask

  // Apply one clock edge worth of the command rules to the model.
  task automatic model_step();
    int period;
    m_done = 0;
    m_wrap = 0;
    if (stop) begin
      m_state = M_IDLE;
      m_phase = 0;
    end else if (m_state == M_IDLE || m_state == M_DONE) begin
      if (load_en) begin
        m_count  = load_val;
        m_reload = load_val;
      end
      if (start) begin
        m_term  = term_val;
        m_mode  = mode;
        m_presc = presc_sel;
        m_phase = 0;
        m_state = M_RUN;
      end
    end else if (m_state == M_RUN) begin
      if (pause) begin
        m_state = M_PAUSED;
      end else begin
        period = 1 << m_presc;
        if ((m_phase % period) == period - 1) begin
          if (m_count == m_term) begin
            if (m_mode == 0) begin
              m_state = M_DONE;
              m_done  = 1;
            end else begin
              m_count = m_reload;
              m_wrap  = 1;
            end
          end else begin
            m_count = (m_count + 1) % 16;
          end
        end
        m_phase++;
      end
    end else begin
      if (start) m_state = M_RUN;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".count"}, count, m_count);
    check({tag, ".state"}, state, m_state);
    check({tag, ".busy"},  busy,  (m_state == M_RUN || m_state == M_PAUSED) ? 1 : 0);
    check({tag, ".done"},  done,  m_done);
    check({tag, ".wrap"},  wrap,  m_wrap);
  endtask

  // One clock: inputs are already driven; advance model at the edge and
  // compare on the following falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic clear_cmds();
    start = 0; pause = 0; stop = 0; load_en = 0;
  endtask

  task automatic launch(input int lv, input int tv, input int md, input int ps);
    load_val = lv; term_val = tv; mode = md; presc_sel = ps;
    load_en = 1; start = 1;
    cycle("launch");
    clear_cmds();
  endtask

  initial begin
    int k;
    int dones;
    int r;
    rst = 1'b1;
    clear_cmds();
    load_val = '0; term_val = '0; mode = 0; presc_sel = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all("reset");
    rst = 1'b0;
    cycle("post_reset");

    // One-shot 3..6 at full rate.
    launch(3, 6, 0, 0);
    check("os.first", count, 3);
    for (int i = 0; i < 3; i++) cycle("os.run");
    check("os.at_term", count, 6);
    cycle("os.term");
    check("os.done", done, 1);
    check("os.state_done", state, 3);
    dones = 1;
    for (int i = 0; i < 3; i++) begin
      cycle("os.hold");
      dones += done;
    end
    check("os.done_once", dones, 1);
    check("os.hold_count", count, 6);

    // Auto-reload 14 -> 1 crossing the 15 -> 0 wrap.
    launch(14, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle("ar.run");
    check("ar.reload1", count, 14);
    check("ar.wrap1", wrap, 1);
    for (int i = 0; i < 4; i++) cycle("ar.run2");
    check("ar.reload2", count, 14);
    check("ar.wrap2", wrap, 1);
    check("ar.state", state, 1);
    stop = 1; cycle("ar.stop"); clear_cmds();

    // Divide-by-4: done twelve cycles after the start edge.
    launch(0, 2, 0, 2);
    k = 0;
    while (!done && k < 40) begin
      cycle("p4.run");
      k++;
    end
    check("p4.latency", k, 12);
    check("p4.count", count, 2);

    // Divide-by-2 with a pause at count 5, then resume.
    launch(0, 15, 0, 1);
    k = 0;
    while (count != 5 && k < 40) begin
      cycle("pz.run");
      k++;
    end
    check("pz.reached5", count, 5);
    pause = 1; cycle("pz.pause"); clear_cmds();
    for (int i = 0; i < 5; i++) cycle("pz.held");
    check("pz.frozen", count, 5);
    check("pz.busy", busy, 1);
    check("pz.state", state, 2);
    start = 1; cycle("pz.resume"); clear_cmds();
    for (int i = 0; i < 3; i++) cycle("pz.after");
    start = 1; load_en = 1; load_val = 0; cycle("pz.start_in_run"); clear_cmds();
    check("pz.still_run", state, 1);
    for (int i = 0; i < 4; i++) cycle("pz.tail");
    stop = 1; cycle("pz.stop"); clear_cmds();

    // Stop coinciding with the terminal tick at count 4.
    launch(0, 4, 0, 0);
    k = 0;
    while (count != 4 && k < 20) begin
      cycle("st.run");
      k++;
    end
    stop = 1; cycle("st.stop"); clear_cmds();
    check("st.state", state, 0);
    check("st.no_done", done, 0);
    check("st.count", count, 4);
    load_en = 1; load_val = 9; cycle("st.load"); clear_cmds();
    check("st.loaded", count, 9);
    pause = 1; cycle("st.pause_idle"); clear_cmds();
    check("st.pause_ignored", state, 0);

    // Asynchronous reset in the middle of a run.
    launch(0, 15, 0, 0);
    k = 0;
    while (count != 7 && k < 20) begin
      cycle("rs.run");
      k++;
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rs.count", count, 0);
    check("rs.state", state, 0);
    check("rs.busy", busy, 0);
    check("rs.done", done, 0);
    check("rs.wrap", wrap, 0);
    @(negedge clk);
    rst = 1'b0;
    cycle("rs.release");

    // Randomized commands; pause and start are never driven together.
    for (int i = 0; i < 3000; i++) begin
      clear_cmds();
      r = $urandom_range(0, 99);
      if      (r < 3)  stop = 1;
      else if (r < 9)  pause = 1;
      else if (r < 17) start = 1;
      else if (r < 23) load_en = 1;
      else if (r < 28) begin start = 1; load_en = 1; end
      load_val  = WIDTH'($urandom_range(0, 15));
      term_val  = WIDTH'($urandom_range(0, 15));
      mode      = 1'($urandom_range(0, 1));
      presc_sel = 2'($urandom_range(0, 3));
      cycle("rnd");
    end
    clear_cmds();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_count_sequencer

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Controller that sequences a 4-bit synchronous up-counter datapath. It provides start, pause, stop and load commands, a programmable terminal count and a programmable prescaler (count every 1, 2, 4 or 8 clocks). In one-shot mode it stops at the terminal count; in auto-reload mode it restarts from the loaded value. It sits between control logic and the counter and supplies status and event pulses to the consumer.

Parameters:
WIDTH, 4, counter/load/terminal width
PRESC_W, 3, prescaler counter width (supports divide 1/2/4/8)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin run (IDLE/DONE) or resume (PAUSED)
pause  in  1  suspend counting (RUN only)
stop  in  1  abort to IDLE from any state
load_en  in  1  load count and reload register (IDLE/DONE only)
load_val  in  WIDTH  load/reload value
term_val  in  WIDTH  terminal count, sampled on accepted start from IDLE/DONE
mode  in  1  0 = one-shot, 1 = auto-reload; sampled with term_val
presc_sel  in  2  count every 2^presc_sel clocks; sampled with term_val
count  out  WIDTH  current counter value
busy  out  1  high in RUN or PAUSED
done  out  1  one-cycle pulse on entry to DONE
wrap  out  1  one-cycle pulse on auto-reload
state  out  2  IDLE=00, RUN=01, PAUSED=10, DONE=11

Behaviour:
- One clock domain: clk. rst is asynchronous and active-high. While rst is high, all registers are forced to reset values: state=IDLE, count=0, reload_reg=0, term_reg=0, mode_reg=0, presc_reg=0, prescaler=0, done=0, wrap=0.
- All outputs are registered except busy, which is decoded from the state register.
- Command priority per cycle: stop > pause > start > load_en. Exception: load_en together with start in IDLE/DONE applies both, and the run begins from load_val.
- Prescaler: free counter cleared on entry to RUN from IDLE/DONE and held in PAUSED. tick = (prescaler == 2^presc_reg - 1), after which the prescaler returns to 0. presc_reg=0 gives a tick every cycle.
- IDLE:
  - load_en: count<=load_val, reload_reg<=load_val.
  - start: term_reg/mode_reg/presc_reg are sampled, prescaler<=0, state->RUN.
  - pause is ignored.
- RUN, on tick:
  - If count==term_reg and mode_reg=0: state->DONE, done=1 for one cycle, count holds.
  - If count==term_reg and mode_reg=1: count<=reload_reg, wrap=1 for one cycle, stay in RUN.
  - Otherwise: count<=count+1, modulo 2^WIDTH (15 -> 0).
  - Non-tick cycles hold count.
  - pause -> PAUSED. start and load_en are ignored.
- PAUSED: count and prescaler hold. start -> RUN with the prescaler phase retained. load_en is ignored.
- DONE: count holds the terminal value. load_en and start behave as in IDLE.
- stop (any state): state->IDLE in the next cycle. count holds; the prescaler is cleared. A stop coinciding with a terminal tick wins: no done pulse, count does not update.
- Latency: the first increment occurs 2^presc_reg cycles after the start edge. done and wrap assert in the same cycle the count reaches its final/reload value.
- term_reg < load value: the counter wraps through 15->0 before matching. term_reg == load value: the first tick matches immediately.
- Input changes to term_val, mode and presc_sel during RUN have no effect until the next start from IDLE/DONE.
- rst asserted mid-run: immediate return to reset values. No pulse is emitted on reset release.

Decomposition:
- Shared package count_seq_pkg:
  - state encoding constants ST_IDLE, ST_RUN, ST_PAUSED, ST_DONE
  - MODE_ONESHOT and MODE_RELOAD constants
- One sub-module: count_prescaler (PRESC_W counter with clear, hold, sel inputs; tick output).
- The FSM, sampled registers and counter datapath stay in count_sequencer.

Test Plan:
- Reset mid-run (rst pulsed high between clock edges during RUN, count=7) -> count=0, state=00, busy=0, done=0 and wrap=0 immediately.
- load_val=3, term_val=6, mode=0, presc_sel=0, load_en+start together -> count 3,4,5,6 on consecutive cycles; done pulses exactly once with count=6; state=11; count holds at 6.
- load_val=14, term_val=1, mode=1, presc_sel=0 -> count 14,15,0,1,14,15,... with wrap pulsing on each return to 14; state stays 01.
- presc_sel=2, load_val=0, term_val=2, mode=0 -> count increments every 4 clocks; done arrives 12 cycles after start.
- presc_sel=1: pause in RUN at count=5 held 5 cycles, then start -> count frozen at 5 with busy=1; counting resumes with the prescaler phase preserved; start during RUN is ignored.
- term_val=4, mode=0: stop in the same cycle as the terminal tick at count=4 -> state IDLE, no done pulse, count=4. Then load_en with load_val=9 -> count=9. Then pause in IDLE -> ignored.
